xif_coproc_frontend: RTL and testbench
======================================

Name: xif_coproc_frontend

Overview:
- Parametrised eXtension-interface (XIF) front-end for the vector accelerator; replaces the hard-wired always-accept XIF stub at the accelerator top.
- Decodes and accepts vector instructions from the core and buffers them with their operands in an in-order queue.
- Resolves commit/kill per instruction ID, dispatches committed instructions one at a time to the vector backend (decoder/VLSU), and returns one XIF result per dispatched instruction.

Parameters:
- XLEN, 32, scalar register and operand width.
- ID_WIDTH, 4, XIF instruction ID width.
- NUM_RS, 2, number of scalar source operands carried per instruction.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  core offers an instruction.
- issue_ready  out  1  front-end can respond this cycle.
- issue_instr  in  32  instruction word.
- issue_id  in  ID_WIDTH  instruction ID.
- issue_rs  in  NUM_RS*XLEN  scalar operands; rs[i] at bits [i*XLEN +: XLEN].
- issue_rs_valid  in  NUM_RS  per-operand valid.
- issue_accept  out  1  instruction is a vector instruction and is taken.
- issue_writeback  out  1  accepted instruction writes a scalar rd.
- issue_loadstore  out  1  accepted instruction is a vector load/store.
- commit_valid  in  1  commit event.
- commit_id  in  ID_WIDTH  ID being committed.
- commit_kill  in  1  1 = discard instruction, 0 = execute.
- disp_valid  out  1  head instruction offered to backend.
- disp_ready  in  1  backend takes instruction.
- disp_instr  out  32  dispatched instruction word.
- disp_rs  out  NUM_RS*XLEN  dispatched operands.
- disp_id  out  ID_WIDTH  dispatched ID.
- be_done  in  1  backend finished the dispatched instruction.
- be_we  in  1  backend result writes rd.
- be_rd_data  in  XLEN  backend scalar result.
- result_valid  out  1  XIF result available.
- result_ready  in  1  core takes result.
- result_id  out  ID_WIDTH  result ID.
- result_we  out  1  rd write enable.
- result_data  out  XLEN  rd data.
- occupancy  out  $clog2(DEPTH+1)  valid queue entries.

Behaviour:
- Reset: queue empty, pointers 0, state IDLE, pending result dropped.
  - Outputs at reset: disp_valid, result_valid, result_id, result_we, result_data, disp_* and occupancy are 0.
  - issue_* outputs are combinational.
- Decode (combinational):
  - Vector opcodes are 1010111 (OP-V), 0000111 (LOAD-FP) and 0100111 (STORE-FP).
  - issue_accept = issue_valid & issue_ready & vector opcode.
  - issue_loadstore = issue_accept & opcode is LOAD-FP or STORE-FP.
  - issue_writeback = issue_accept & OP-V & (funct3 = 111, or funct3 = 010 with funct6 = 010000).
- Issue handshake:
  - issue_ready = (occupancy < DEPTH) & (all issue_rs_valid).
  - Transaction occurs when issue_valid & issue_ready.
  - An accepted transaction enqueues {instr, rs, id, committed=0, killed=0} at the tail.
  - A rejected transaction (accept=0) is not stored.
- Commit:
  - Applied to the valid entry whose id equals commit_id: sets committed, plus killed if commit_kill.
  - A commit that matches no entry is ignored.
  - Commit in the same cycle as the enqueue of the same ID applies to the new entry.
- Dispatch FSM:
  - IDLE:
    - Head valid & committed & !killed: go to DISP.
    - Head killed: pop head in one cycle, no dispatch, no result.
  - DISP:
    - disp_valid = 1, with disp_* driven from the head entry.
    - On disp_ready: pop head, latch id, go to EXEC.
    - disp_* stay stable while disp_ready = 0.
  - EXEC:
    - Wait for be_done (be_done is ignored in other states).
    - On be_done: latch result_id, result_we = be_we, result_data = be_rd_data; go to RESP.
  - RESP:
    - result_valid = 1, result fields held stable.
    - On result_ready: go to IDLE.
    - Next dispatch is earliest the cycle after.
- Queue:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Simultaneous enqueue and pop leaves occupancy unchanged.
  - Full: issue_ready = 0. Empty: no dispatch.
- Ordering: strictly in order; exactly one result per dispatched instruction; killed instructions produce no result.
- Reset mid-operation flushes everything, including an in-flight EXEC/RESP.

Test Plan:
- Basic flow:
  - Stimulus: vadd.vv 0x02208057, id=3, rs valid; next cycle commit id=3, kill=0.
  - Required: accept=1, writeback=0; disp_valid with disp_id=3; after disp_ready and be_done (we=0), result_valid with id=3, we=0.
- Reject:
  - Stimulus: issue 0x00000013 (addi).
  - Required: issue_accept=0, occupancy stays 0, no dispatch.
- Full queue (DEPTH=4):
  - Stimulus: issue ids 0..3 without commit, then offer a 5th; afterwards commit 0..3.
  - Required: issue_ready=0 for the 5th and occupancy=4; dispatches occur in order 0,1,2,3 and occupancy returns to 0.
- Kill:
  - Stimulus: issue ids 1,2; commit id1 kill=1, then id2 kill=0.
  - Required: only id2 dispatched; only one result (id=2).
- Writeback result with backpressure:
  - Stimulus: vsetvli (OP-V, funct3=111); be_we=1, be_rd_data=4; result_ready low for 3 cycles.
  - Required: issue_writeback=1; result_valid, data=4, we=1 held stable for 3 cycles; FSM returns to IDLE after ready.
- Reset mid-operation:
  - Stimulus: assert n_reset low while in EXEC with 2 entries queued.
  - Required: occupancy=0, disp_valid=0, result_valid=0 immediately; no stale result after release.

Source files
------------

// File: rtl/xif_coproc_frontend_if.sv
// XIF front-end bundle: issue, commit, dispatch, backend completion and result.
// The master side is the core plus the vector backend; the slave side is the front-end.
interface xif_coproc_frontend_if #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4,
  parameter int NUM_RS   = 2
);
  logic                     issue_valid;
  logic                     issue_ready;
  logic [31:0]              issue_instr;
  logic [ID_WIDTH-1:0]      issue_id;
  logic [NUM_RS*XLEN-1:0]   issue_rs;
  logic [NUM_RS-1:0]        issue_rs_valid;
  logic                     issue_accept;
  logic                     issue_writeback;
  logic                     issue_loadstore;

  logic                     commit_valid;
  logic [ID_WIDTH-1:0]      commit_id;
  logic                     commit_kill;

  logic                     disp_valid;
  logic                     disp_ready;
  logic [31:0]              disp_instr;
  logic [NUM_RS*XLEN-1:0]   disp_rs;
  logic [ID_WIDTH-1:0]      disp_id;

  logic                     be_done;
  logic                     be_we;
  logic [XLEN-1:0]          be_rd_data;

  logic                     result_valid;
  logic                     result_ready;
  logic [ID_WIDTH-1:0]      result_id;
  logic                     result_we;
  logic [XLEN-1:0]          result_data;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    input  issue_ready, issue_accept, issue_writeback, issue_loadstore,
    output commit_valid, commit_id, commit_kill,
    input  disp_valid, disp_instr, disp_rs, disp_id,
    output disp_ready, be_done, be_we, be_rd_data,
    input  result_valid, result_id, result_we, result_data,
    output result_ready
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    output issue_ready, issue_accept, issue_writeback, issue_loadstore,
    input  commit_valid, commit_id, commit_kill,
    output disp_valid, disp_instr, disp_rs, disp_id,
    input  disp_ready, be_done, be_we, be_rd_data,
    output result_valid, result_id, result_we, result_data,
    input  result_ready
  );
endinterface

// File: rtl/xif_coproc_frontend.sv
// XIF front-end for the vector accelerator: decodes and accepts vector
// instructions, holds them in an in-order queue until commit/kill, dispatches
// committed ones to the backend one at a time and returns one result each.
module xif_coproc_frontend #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4,
  parameter int NUM_RS   = 2,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         n_reset,
  xif_coproc_frontend_if.slave         xif,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int RSW = NUM_RS * XLEN;

  typedef enum logic [1:0] {IDLE, DISP, EXEC, RESP} state_e;

  state_e                state_q, state_d;

  logic [31:0]           entryInstr_q [DEPTH];
  logic [RSW-1:0]        entryRs_q    [DEPTH];
  logic [ID_WIDTH-1:0]   entryId_q    [DEPTH];
  logic [DEPTH-1:0]      entryVld_q;
  logic [DEPTH-1:0]      entryCmt_q;
  logic [DEPTH-1:0]      entryKill_q;
  logic [PW-1:0]         headPtr_q, tailPtr_q;
  logic [CW-1:0]         count_q;

  logic [ID_WIDTH-1:0]   execId_q;
  logic [ID_WIDTH-1:0]   resultId_q;
  logic                  resultWe_q;
  logic [XLEN-1:0]       resultData_q;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [5:0]            funct6;
  logic                  isOpV, isLoadStore, enq, pop, newCommitHit;
  logic                  headVld, headCmt, headKill;

  assign opcode      = xif.issue_instr[6:0];
  assign funct3      = xif.issue_instr[14:12];
  assign funct6      = xif.issue_instr[31:26];
  assign isOpV       = (opcode == 7'b1010111);
  assign isLoadStore = (opcode == 7'b0000111) || (opcode == 7'b0100111);

  assign xif.issue_ready     = (count_q < CW'(DEPTH)) && (&xif.issue_rs_valid);
  assign xif.issue_accept    = xif.issue_valid && xif.issue_ready && (isOpV || isLoadStore);
  assign xif.issue_loadstore = xif.issue_accept && isLoadStore;
  assign xif.issue_writeback = xif.issue_accept && isOpV &&
                               ((funct3 == 3'b111) || ((funct3 == 3'b010) && (funct6 == 6'b010000)));

  assign enq          = xif.issue_accept;
  assign newCommitHit = xif.commit_valid && (xif.commit_id == xif.issue_id);

  assign headVld  = entryVld_q[headPtr_q];
  assign headCmt  = entryCmt_q[headPtr_q];
  assign headKill = entryKill_q[headPtr_q];

  assign occupancy        = count_q;
  assign xif.result_id    = resultId_q;
  assign xif.result_we    = resultWe_q;
  assign xif.result_data  = resultData_q;

  // Dispatch FSM state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Dispatch FSM next-state: one instruction in flight from dispatch to result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (headVld && headCmt && !headKill) state_d = DISP;
      DISP:    if (xif.disp_ready)   state_d = EXEC;
      EXEC:    if (xif.be_done)      state_d = RESP;
      RESP:    if (xif.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dispatch FSM outputs; disp_* read zero outside DISP, killed heads drop in IDLE.
  always_comb begin
    pop              = 1'b0;
    xif.disp_valid   = 1'b0;
    xif.disp_instr   = '0;
    xif.disp_rs      = '0;
    xif.disp_id      = '0;
    xif.result_valid = (state_q == RESP);
    case (state_q)
      IDLE: pop = headVld && headKill;
      DISP: begin
        xif.disp_valid = 1'b1;
        xif.disp_instr = entryInstr_q[headPtr_q];
        xif.disp_rs    = entryRs_q[headPtr_q];
        xif.disp_id    = entryId_q[headPtr_q];
        pop            = xif.disp_ready;
      end
      default: ;
    endcase
  end

  // Instruction queue: commit marking, head pop and tail enqueue.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryInstr_q[i] <= '0;
        entryRs_q[i]    <= '0;
        entryId_q[i]    <= '0;
      end
      entryVld_q  <= '0;
      entryCmt_q  <= '0;
      entryKill_q <= '0;
      headPtr_q   <= '0;
      tailPtr_q   <= '0;
      count_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (xif.commit_valid && entryVld_q[i] && (entryId_q[i] == xif.commit_id)) begin
          entryCmt_q[i] <= 1'b1;
          if (xif.commit_kill) entryKill_q[i] <= 1'b1;
        end
      end
      if (pop) begin
        entryVld_q[headPtr_q] <= 1'b0;
        headPtr_q             <= headPtr_q + PW'(1);
      end
      if (enq) begin
        entryVld_q[tailPtr_q]   <= 1'b1;
        entryInstr_q[tailPtr_q] <= xif.issue_instr;
        entryRs_q[tailPtr_q]    <= xif.issue_rs;
        entryId_q[tailPtr_q]    <= xif.issue_id;
        entryCmt_q[tailPtr_q]   <= newCommitHit;
        entryKill_q[tailPtr_q]  <= newCommitHit && xif.commit_kill;
        tailPtr_q               <= tailPtr_q + PW'(1);
      end
      count_q <= count_q + CW'(enq) - CW'(pop);
    end
  end

  // In-flight ID and the result captured when the backend finishes.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      execId_q     <= '0;
      resultId_q   <= '0;
      resultWe_q   <= 1'b0;
      resultData_q <= '0;
    end else begin
      if ((state_q == DISP) && xif.disp_ready) execId_q <= entryId_q[headPtr_q];
      if ((state_q == EXEC) && xif.be_done) begin
        resultId_q   <= execId_q;
        resultWe_q   <= xif.be_we;
        resultData_q <= xif.be_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_xif_coproc_frontend.sv
// Directed bench for xif_coproc_frontend: a decode vector table plus
// hand-written sequences for queueing, commit/kill, backpressure and reset.
module tb_xif_coproc_frontend;

  localparam int XLEN  = 32;
  localparam int IDW   = 4;
  localparam int NRS   = 2;
  localparam int DEPTH = 4;

  localparam logic [31:0] VADD    = 32'h02208057;
  localparam logic [31:0] VSETVLI = 32'h0D0572D7;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [2:0] occupancy;
  int         cmpCount = 0;
  int         errCount = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  rsValid;
    logic        expReady;
    logic        expAccept;
    logic        expWb;
    logic        expLs;
  } vec_t;

  vec_t vecs [10];

  xif_coproc_frontend_if #(.XLEN(XLEN), .ID_WIDTH(IDW), .NUM_RS(NRS)) bus ();

  xif_coproc_frontend #(.XLEN(XLEN), .ID_WIDTH(IDW), .NUM_RS(NRS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .xif       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkRs(input logic [3:0] id);
    return {28'hB000000, id, 28'hA000000, id};
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] id,
                               input logic expAccept, input logic expWb, input string name);
    bus.issue_valid    = 1'b1;
    bus.issue_instr    = instr;
    bus.issue_id       = id;
    bus.issue_rs       = mkRs(id);
    bus.issue_rs_valid = 2'b11;
    #1;
    checkOutput({name, " accept"}, 64'(bus.issue_accept), 64'(expAccept));
    checkOutput({name, " writeback"}, 64'(bus.issue_writeback), 64'(expWb));
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic applyCommit(input logic [3:0] id, input logic kill);
    bus.commit_valid = 1'b1;
    bus.commit_id    = id;
    bus.commit_kill  = kill;
    step();
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
  endtask

  task automatic waitDisp(input logic [3:0] expId, input logic [31:0] expInstr, input string name);
    int n = 0;
    while (!bus.disp_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.disp_valid) begin
      checkOutput({name, " disp_valid timeout"}, 64'(bus.disp_valid), 64'(1));
    end else begin
      checkOutput({name, " disp_id"}, 64'(bus.disp_id), 64'(expId));
      checkOutput({name, " disp_instr"}, 64'(bus.disp_instr), 64'(expInstr));
      checkOutput({name, " disp_rs"}, bus.disp_rs, mkRs(expId));
      bus.disp_ready = 1'b1;
      step();
      bus.disp_ready = 1'b0;
    end
  endtask

  task automatic finishBackend(input logic we, input logic [31:0] data);
    bus.be_done    = 1'b1;
    bus.be_we      = we;
    bus.be_rd_data = data;
    step();
    bus.be_done    = 1'b0;
    bus.be_we      = 1'b0;
    bus.be_rd_data = '0;
  endtask

  task automatic waitResult(input logic [3:0] expId, input logic expWe, input logic [31:0] expData,
                            input string name);
    int n = 0;
    while (!bus.result_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.result_valid) begin
      checkOutput({name, " result_valid timeout"}, 64'(bus.result_valid), 64'(1));
    end else begin
      checkOutput({name, " result_id"}, 64'(bus.result_id), 64'(expId));
      checkOutput({name, " result_we"}, 64'(bus.result_we), 64'(expWe));
      checkOutput({name, " result_data"}, 64'(bus.result_data), 64'(expData));
      bus.result_ready = 1'b1;
      step();
      bus.result_ready = 1'b0;
    end
  endtask

  // Watches for any dispatch or result over a window where none may appear.
  task automatic expectQuiet(input int cycles, input string name);
    logic seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.disp_valid || bus.result_valid) seen = 1'b1;
      step();
    end
    checkOutput({name, " unexpected disp/result"}, 64'(seen), 64'(0));
  endtask

  initial begin
    // Decode table: {instr, rs_valid, ready, accept, writeback, loadstore}.
    vecs[0] = '{VADD,         2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{VSETVLI,      2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h422022D7, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h022022D7, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h422002D7, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0205E087, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0205E027, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000F007, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{32'h00000013, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{VSETVLI,      2'b01, 1'b0, 1'b0, 1'b0, 1'b0};

    n_reset            = 1'b0;
    bus.issue_valid    = 1'b0;
    bus.issue_instr    = '0;
    bus.issue_id       = '0;
    bus.issue_rs       = '0;
    bus.issue_rs_valid = '0;
    bus.commit_valid   = 1'b0;
    bus.commit_id      = '0;
    bus.commit_kill    = 1'b0;
    bus.disp_ready     = 1'b0;
    bus.be_done        = 1'b0;
    bus.be_we          = 1'b0;
    bus.be_rd_data     = '0;
    bus.result_ready   = 1'b0;

    // Reset state.
    step();
    step();
    checkOutput("reset occupancy", 64'(occupancy), 64'(0));
    checkOutput("reset disp_valid", 64'(bus.disp_valid), 64'(0));
    checkOutput("reset disp_id", 64'(bus.disp_id), 64'(0));
    checkOutput("reset disp_instr", 64'(bus.disp_instr), 64'(0));
    checkOutput("reset result_valid", 64'(bus.result_valid), 64'(0));
    checkOutput("reset result_id", 64'(bus.result_id), 64'(0));
    checkOutput("reset result_we", 64'(bus.result_we), 64'(0));
    checkOutput("reset result_data", 64'(bus.result_data), 64'(0));
    n_reset = 1'b1;
    step();

    // Combinational decode; issue_valid drops before each edge so nothing is stored.
    for (int i = 0; i < 10; i++) begin
      bus.issue_valid    = 1'b1;
      bus.issue_instr    = vecs[i].instr;
      bus.issue_id       = 4'd0;
      bus.issue_rs_valid = vecs[i].rsValid;
      #1;
      checkOutput($sformatf("vec%0d ready", i), 64'(bus.issue_ready), 64'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d accept", i), 64'(bus.issue_accept), 64'(vecs[i].expAccept));
      checkOutput($sformatf("vec%0d writeback", i), 64'(bus.issue_writeback), 64'(vecs[i].expWb));
      checkOutput($sformatf("vec%0d loadstore", i), 64'(bus.issue_loadstore), 64'(vecs[i].expLs));
      bus.issue_valid = 1'b0;
      step();
    end
    checkOutput("decode table occupancy", 64'(occupancy), 64'(0));

    // Basic flow.
    applyStimulus(VADD, 4'd3, 1'b1, 1'b0, "basic");
    checkOutput("basic occupancy after issue", 64'(occupancy), 64'(1));
    applyCommit(4'd3, 1'b0);
    waitDisp(4'd3, VADD, "basic");
    checkOutput("basic occupancy after dispatch", 64'(occupancy), 64'(0));
    finishBackend(1'b0, 32'h55);
    waitResult(4'd3, 1'b0, 32'h55, "basic");
    checkOutput("basic result_valid after ready", 64'(bus.result_valid), 64'(0));

    // Reject a scalar instruction.
    applyStimulus(32'h00000013, 4'd5, 1'b0, 1'b0, "reject");
    checkOutput("reject occupancy", 64'(occupancy), 64'(0));
    applyCommit(4'd5, 1'b0);
    expectQuiet(5, "reject");

    // Full queue, pointers wrap since head/tail start at 1.
    for (int k = 0; k < 4; k++)
      applyStimulus(VADD + (k << 7), 4'(k), 1'b1, 1'b0, $sformatf("full id%0d", k));
    checkOutput("full occupancy", 64'(occupancy), 64'(4));
    bus.issue_valid    = 1'b1;
    bus.issue_instr    = VADD;
    bus.issue_id       = 4'd4;
    bus.issue_rs_valid = 2'b11;
    #1;
    checkOutput("full 5th issue_ready", 64'(bus.issue_ready), 64'(0));
    checkOutput("full 5th accept", 64'(bus.issue_accept), 64'(0));
    step();
    bus.issue_valid = 1'b0;
    checkOutput("full occupancy after 5th", 64'(occupancy), 64'(4));
    for (int k = 0; k < 4; k++) applyCommit(4'(k), 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitDisp(4'(k), VADD + (k << 7), $sformatf("full disp%0d", k));
      finishBackend(1'b0, 32'(k + 16));
      waitResult(4'(k), 1'b0, 32'(k + 16), $sformatf("full res%0d", k));
    end
    checkOutput("full occupancy drained", 64'(occupancy), 64'(0));

    // Kill: id1 discarded, id2 executes.
    applyStimulus(VADD, 4'd1, 1'b1, 1'b0, "kill id1");
    applyStimulus(VADD + 32'h80, 4'd2, 1'b1, 1'b0, "kill id2");
    applyCommit(4'd1, 1'b1);
    applyCommit(4'd2, 1'b0);
    waitDisp(4'd2, VADD + 32'h80, "kill");
    finishBackend(1'b1, 32'h1234);
    waitResult(4'd2, 1'b1, 32'h1234, "kill");
    expectQuiet(5, "kill");
    checkOutput("kill occupancy", 64'(occupancy), 64'(0));

    // Writeback result held under backpressure.
    applyStimulus(VSETVLI, 4'd7, 1'b1, 1'b1, "wb");
    applyCommit(4'd7, 1'b0);
    waitDisp(4'd7, VSETVLI, "wb");
    finishBackend(1'b1, 32'd4);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("wb hold%0d result_valid", c), 64'(bus.result_valid), 64'(1));
      checkOutput($sformatf("wb hold%0d result_id", c), 64'(bus.result_id), 64'(7));
      checkOutput($sformatf("wb hold%0d result_we", c), 64'(bus.result_we), 64'(1));
      checkOutput($sformatf("wb hold%0d result_data", c), 64'(bus.result_data), 64'(4));
      step();
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    checkOutput("wb result_valid after ready", 64'(bus.result_valid), 64'(0));
    checkOutput("wb disp_valid after ready", 64'(bus.disp_valid), 64'(0));

    // Reset while in EXEC with two entries still queued.
    applyStimulus(VADD, 4'd8, 1'b1, 1'b0, "rst id8");
    applyStimulus(VADD, 4'd9, 1'b1, 1'b0, "rst id9");
    applyStimulus(VADD, 4'd10, 1'b1, 1'b0, "rst id10");
    applyCommit(4'd8, 1'b0);
    waitDisp(4'd8, VADD, "rst");
    checkOutput("rst occupancy in EXEC", 64'(occupancy), 64'(2));
    n_reset = 1'b0;
    #1;
    checkOutput("rst occupancy", 64'(occupancy), 64'(0));
    checkOutput("rst disp_valid", 64'(bus.disp_valid), 64'(0));
    checkOutput("rst result_valid", 64'(bus.result_valid), 64'(0));
    step();
    n_reset = 1'b1;
    step();
    finishBackend(1'b1, 32'hDEAD);
    applyCommit(4'd9, 1'b0);
    expectQuiet(6, "rst after release");
    checkOutput("rst occupancy after release", 64'(occupancy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
